// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter with a registered write port, busy scoreboard and RAW hazard flags.
// Optional macro REGFILE_WB_BYPASS_EN adds bypass data outputs and masks hazards during the write cycle.
module regfile_wb_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int NREQ  = 3,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic                  we0,
    output logic [AW-1:0]         wr_addr0,
    output logic [WIDTH-1:0]      wr_din0,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_addr,
    input  logic [AW-1:0]         rd_addr0,
    input  logic [AW-1:0]         rd_addr1,
    output logic                  hazard0,
    output logic                  hazard1,
    output logic [DEPTH-1:0]      busy_vec,
    output logic                  err
`ifdef REGFILE_WB_BYPASS_EN
    ,
    output logic [WIDTH-1:0]      byp_data0,
    output logic [WIDTH-1:0]      byp_data1
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]    ptr_q, ptr_d;
    logic             we0_q, we0_d;
    logic [AW-1:0]    wr_addr0_q, wr_addr0_d;
    logic [WIDTH-1:0] wr_din0_q, wr_din0_d;
    logic [DEPTH-1:0] busy_q, busy_d;
    logic             err_q, err_d;

    logic [NREQ-1:0]  grant;
    logic [PW-1:0]    grant_idx;
    logic             found;
    logic             accept;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_data;
    logic [PW-1:0]    idx;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    assign req_ready = rst ? '0 : grant;
    assign accept    = found & ~rst;
    assign sel_addr  = req_addr[int'(grant_idx)*AW +: AW];
    assign sel_data  = req_data[int'(grant_idx)*WIDTH +: WIDTH];

    always_comb begin
        ptr_d      = ptr_q;
        we0_d      = 1'b0;
        wr_addr0_d = wr_addr0_q;
        wr_din0_d  = wr_din0_q;
        if (accept) begin
            ptr_d      = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            we0_d      = (sel_addr != '0);
            wr_addr0_d = sel_addr;
            wr_din0_d  = sel_data;
        end
    end

    // Clear from the write port first so a same-edge issue to that address wins.
    always_comb begin
        busy_d = busy_q;
        err_d  = err_q;
        if (we0_q) begin
            busy_d[wr_addr0_q] = 1'b0;
        end
        if (issue_valid && issue_addr != '0) begin
            busy_d[issue_addr] = 1'b1;
            if (busy_q[issue_addr] && !(we0_q && wr_addr0_q == issue_addr)) begin
                err_d = 1'b1;
            end
        end
        if (accept && sel_addr != '0 && !busy_q[sel_addr]) begin
            err_d = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            we0_q      <= 1'b0;
            wr_addr0_q <= '0;
            wr_din0_q  <= '0;
            busy_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            we0_q      <= we0_d;
            wr_addr0_q <= wr_addr0_d;
            wr_din0_q  <= wr_din0_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign we0      = we0_q;
    assign wr_addr0 = wr_addr0_q;
    assign wr_din0  = wr_din0_q;
    assign busy_vec = busy_q;
    assign err      = err_q;

`ifdef REGFILE_WB_BYPASS_EN
    assign byp_data0 = wr_din0_q;
    assign byp_data1 = wr_din0_q;
    assign hazard0   = busy_q[rd_addr0] & (rd_addr0 != '0) & ~(we0_q & (wr_addr0_q == rd_addr0));
    assign hazard1   = busy_q[rd_addr1] & (rd_addr1 != '0) & ~(we0_q & (wr_addr0_q == rd_addr1));
`else
    assign hazard0   = busy_q[rd_addr0] & (rd_addr0 != '0);
    assign hazard1   = busy_q[rd_addr1] & (rd_addr1 != '0);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, output stage, scoreboard, err and reset.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_regfile_wb_arbiter;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int NREQ  = 3;
    localparam int AW    = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  we0;
    logic [AW-1:0]         wr_addr0;
    logic [WIDTH-1:0]      wr_din0;
    logic                  issue_valid;
    logic [AW-1:0]         issue_addr;
    logic [AW-1:0]         rd_addr0;
    logic [AW-1:0]         rd_addr1;
    logic                  hazard0;
    logic                  hazard1;
    logic [DEPTH-1:0]      busy_vec;
    logic                  err;
`ifdef REGFILE_WB_BYPASS_EN
    logic [WIDTH-1:0]      byp_data0;
    logic [WIDTH-1:0]      byp_data1;
    localparam logic       HAZ_IN_WE = 1'b0;
`else
    localparam logic       HAZ_IN_WE = 1'b1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .we0        (we0),
        .wr_addr0   (wr_addr0),
        .wr_din0    (wr_din0),
        .issue_valid(issue_valid),
        .issue_addr (issue_addr),
        .rd_addr0   (rd_addr0),
        .rd_addr1   (rd_addr1),
        .hazard0    (hazard0),
        .hazard1    (hazard1),
        .busy_vec   (busy_vec),
        .err        (err)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .byp_data0  (byp_data0),
        .byp_data1  (byp_data1)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_addr  = '0;
        rd_addr0    = '0;
        rd_addr1    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        req_valid = 3'b111;
        cyc();
        #1;
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_we0",   64'(we0),       64'h0);
        check("rst_busy",  64'(busy_vec),  64'h0);
        check("rst_err",   64'(err),       64'h0);
        cyc();
        rst       = 1'b0;
        req_valid = '0;

        // Single ALU write to r5 after issue.
        issue_valid = 1'b1;
        issue_addr  = 5'd5;
        #1;
        check("t1_busy_pre", 64'(busy_vec), 64'h0);
        cyc();
        issue_valid           = 1'b0;
        req_valid             = 3'b001;
        req_addr[0 +: AW]     = 5'd5;
        req_data[0 +: WIDTH]  = 32'hDEAD_BEEF;
        rd_addr0              = 5'd5;
        rd_addr1              = 5'd5;
        #1;
        check("t1_busy_set", 64'(busy_vec),  64'h20);
        check("t1_ready",    64'(req_ready), 64'h1);
        check("t1_haz0_pre", 64'(hazard0),   64'h1);
        check("t1_haz1_pre", 64'(hazard1),   64'h1);
        cyc();
        req_valid = '0;
        #1;
        check("t1_we0",     64'(we0),      64'h1);
        check("t1_waddr",   64'(wr_addr0), 64'd5);
        check("t1_wdata",   64'(wr_din0),  64'hDEAD_BEEF);
        check("t1_haz0_we", 64'(hazard0),  64'(HAZ_IN_WE));
        check("t1_haz1_we", 64'(hazard1),  64'(HAZ_IN_WE));
`ifdef REGFILE_WB_BYPASS_EN
        check("t1_byp0", 64'(byp_data0), 64'hDEAD_BEEF);
        check("t1_byp1", 64'(byp_data1), 64'hDEAD_BEEF);
`endif
        cyc();
        #1;
        check("t1_busy_clr", 64'(busy_vec), 64'h0);
        check("t1_haz0_off", 64'(hazard0),  64'h0);
        check("t1_we0_off",  64'(we0),      64'h0);
        check("t1_err",      64'(err),      64'h0);

        // All three requesters held high: grants rotate 0,1,2,0,1,2.
        do_reset();
        for (int a = 1; a <= 3; a++) begin
            issue_valid = 1'b1;
            issue_addr  = AW'(a);
            cyc();
        end
        issue_valid = 1'b0;
        req_valid   = 3'b111;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]       = AW'(i + 1);
            req_data[i*WIDTH +: WIDTH] = 32'h11 * (i + 1);
        end
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("t2_grant%0d", c), 64'(req_ready), 64'(1 << (c % 3)));
            if (c > 0) begin
                check($sformatf("t2_we%0d", c),    64'(we0),      64'h1);
                check($sformatf("t2_waddr%0d", c), 64'(wr_addr0), 64'(((c - 1) % 3) + 1));
            end
            cyc();
        end
        req_valid = '0;
        #1;
        check("t2_we_last",    64'(we0),      64'h1);
        check("t2_waddr_last", 64'(wr_addr0), 64'd3);
        check("t2_wdata_last", 64'(wr_din0),  64'h33);
        cyc();
        #1;
        check("t2_we_done", 64'(we0), 64'h0);
        // Second round wrote registers that were no longer busy.
        check("t2_err", 64'(err), 64'h1);

        // LSU write to r0 is consumed silently and advances the pointer.
        do_reset();
        req_valid          = 3'b010;
        req_addr[AW +: AW] = 5'd0;
        #1;
        check("t3_ready", 64'(req_ready), 64'h2);
        cyc();
        req_valid = 3'b111;
        #1;
        check("t3_we0",   64'(we0),       64'h0);
        check("t3_busy",  64'(busy_vec),  64'h0);
        check("t3_err",   64'(err),       64'h0);
        check("t3_ptr",   64'(req_ready), 64'h4);
        req_valid = '0;

        // Double issue to r7 is a sticky error.
        do_reset();
        issue_valid = 1'b1;
        issue_addr  = 5'd7;
        cyc();
        #1;
        check("t4_err_first",  64'(err),      64'h0);
        check("t4_busy_first", 64'(busy_vec), 64'h80);
        cyc();
        issue_valid = 1'b0;
        #1;
        check("t4_err_second",  64'(err),      64'h1);
        check("t4_busy_second", 64'(busy_vec), 64'h80);
        cyc();
        cyc();
        #1;
        check("t4_err_sticky", 64'(err), 64'h1);

        // Reset while a write sits in the output stage.
        do_reset();
        #1;
        check("t5_err_cleared", 64'(err), 64'h0);
        issue_valid = 1'b1;
        issue_addr  = 5'd4;
        cyc();
        issue_valid          = 1'b0;
        req_valid            = 3'b001;
        req_addr[0 +: AW]    = 5'd4;
        req_data[0 +: WIDTH] = 32'h1234;
        cyc();
        req_valid = '0;
        rst       = 1'b1;
        #1;
        check("t5_we0_pending", 64'(we0), 64'h1);
        cyc();
        rst       = 1'b0;
        req_valid = 3'b111;
        #1;
        check("t5_we0_dropped", 64'(we0),       64'h0);
        check("t5_busy",        64'(busy_vec),  64'h0);
        check("t5_ptr",         64'(req_ready), 64'h1);
        cyc();
        req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writeback controller in front of the 2-read/1-write register file.
- Shares the single write port (we0/wr_addr0/wr_din0) among NREQ producers (ALU, load unit, mul/div) with round-robin arbitration and a registered output stage.
- Keeps a busy scoreboard of destinations issued but not yet written, and flags read-after-write hazards on the two read addresses for the issue stage.

Parameters:
- WIDTH, 32, data width of the register file.
- DEPTH, 32, number of registers; AW = $clog2(DEPTH).
- NREQ, 3, number of writeback requesters; index 0 = ALU, 1 = LSU, 2 = MULDIV.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  per-requester write request.
- req_ready  out  NREQ  per-requester grant, combinational.
- req_addr  in  NREQ*AW  packed destination addresses; requester i at [i*AW +: AW].
- req_data  in  NREQ*WIDTH  packed write data; requester i at [i*WIDTH +: WIDTH].
- we0  out  1  register file write enable, registered.
- wr_addr0  out  AW  register file write address, registered.
- wr_din0  out  WIDTH  register file write data, registered.
- issue_valid  in  1  instruction issued with a destination register.
- issue_addr  in  AW  destination of the issued instruction.
- rd_addr0  in  AW  read address 0 of the issuing instruction.
- rd_addr1  in  AW  read address 1 of the issuing instruction.
- hazard0  out  1  rd_addr0 has a pending write, combinational.
- hazard1  out  1  rd_addr1 has a pending write, combinational.
- busy_vec  out  DEPTH  scoreboard bits; bit 0 is always 0.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (rst=1 at posedge):
  - ptr=0, we0=0, wr_addr0=0, wr_din0=0, busy_vec=0, err=0.
  - Any write held in the output stage is dropped.
  - req_ready=0 for every requester while rst=1.
- Arbitration:
  - Search from ptr upward, mod NREQ, for the first requester with req_valid=1.
  - Only that requester gets req_ready=1; all other ready bits are 0.
  - req_ready never depends on a requester's own later state; the output stage accepts one write per cycle, so there is no backpressure beyond arbitration.
  - Accept occurs when req_valid[i] & req_ready[i] at a posedge.
  - On accept: ptr <= (i+1) mod NREQ. With no accept, ptr holds.
- Output stage:
  - On accept of index i with address a and data d, the next cycle has wr_addr0=a and wr_din0=d.
  - we0=1 in that cycle if a != 0. If a == 0, we0=0; the write is consumed silently.
  - we0 is a one-cycle pulse per accept; back-to-back accepts give back-to-back pulses.
  - Latency from req accept to we0: 1 cycle. The register file commits at the following edge.
- Scoreboard:
  - issue_valid=1 with issue_addr != 0 sets busy[issue_addr] at the posedge.
  - A posedge where we0=1 clears busy[wr_addr0].
  - Same edge, set and clear on the same address: set wins (new producer).
  - issue_valid with issue_addr == 0: no effect.
  - issue_valid to an address already busy and not being cleared that edge sets err=1 (sticky until rst); the busy bit stays 1.
  - An accept whose req_addr != 0 has busy=0 sets err=1; the write proceeds anyway.
- Hazards:
  - hazard0 = busy[rd_addr0] & (rd_addr0 != 0).
  - hazard1 = busy[rd_addr1] & (rd_addr1 != 0).
  - Both remain 1 during the we0 cycle for that address; they drop the cycle after.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - Extra outputs byp_data0 and byp_data1 (WIDTH each), equal to wr_din0.
  - hazard0 is forced to 0 when we0=1 & wr_addr0 == rd_addr0; the consumer selects byp_data0 in that case. Same for port 1.
  - Hazard-to-ready latency shortens by one cycle.
- Undefined: the bypass ports are absent and hazard behaves exactly as in Behaviour.

Test Plan:
- Reset, then issue_valid with addr 5; ALU req addr 5, data 0xDEADBEEF:
  - busy_vec[5]=1 one cycle after issue.
  - req_ready[0]=1 while the request is presented.
  - Next cycle: we0=1, wr_addr0=5, wr_din0=0xDEADBEEF.
  - The cycle after: busy_vec[5]=0 and hazard0 with rd_addr0=5 is 0.
- All three req_valid held high for 6 cycles, distinct busy addresses 1/2/3 -> grants in order 0,1,2,0,1,2; we0 high on 6 consecutive cycles.
- LSU req with addr 0 -> accepted, we0 stays 0, busy_vec unchanged, err=0.
- Issue addr 7 twice without an intervening write -> err=1 after the second edge; it stays 1 until rst.
- rst asserted in the cycle after an accept (we0 would be 1) -> we0=0, busy_vec=0, ptr=0 after that edge; no write reaches the register file.
- With REGFILE_WB_BYPASS_EN and rd_addr0=9, write to 9 in flight -> in the we0 cycle hazard0=0 and byp_data0 equals the written data. Without the macro, hazard0=1 in that cycle.
